// File: rtl/alu_decode_mem_core.sv
// rtl/alu_decode_mem_core.sv - execution slice: instruction decoder, 16-op ALU, data memory
// Optional feature macro: ALU_MULDIV_EN (builds the MUL/DIV opcodes; otherwise they return 0)
module alu_decode_mem_core #(
  parameter int WIDTH     = 19,
  parameter int MEM_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       opcode,
  output logic [3:0]       rd,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             zero,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_write,
  input  logic             mem_read,
  output logic [WIDTH-1:0] mem_rdata
);

  localparam int               AW      = $clog2(MEM_DEPTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(MEM_DEPTH);

  logic [WIDTH-1:0] w_alu_result;
  logic             w_addr_in_range;
  logic [AW-1:0]    w_mem_index;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_result_valid;
  logic [WIDTH-1:0] r_mem_rdata;
  logic [WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  // Field extraction is independent of instr_valid so the register file can read early.
  assign opcode = instruction[18:15];
  assign rd     = instruction[14:11];
  assign rs1    = instruction[10:7];
  assign rs2    = instruction[6:3];
  assign imm    = {{(WIDTH-11){1'b0}}, instruction[10:0]};

  // ALU datapath; every result wraps modulo 2^WIDTH, unused opcodes give 0.
  always_comb begin
    w_alu_result = '0;
    case (opcode)
      4'd0: w_alu_result = op_a + op_b;
      4'd1: w_alu_result = op_a - op_b;
`ifdef ALU_MULDIV_EN
      4'd2: w_alu_result = op_a * op_b;
      4'd3: w_alu_result = (op_b == '0) ? '1 : (op_a / op_b);
`else
      4'd2: w_alu_result = '0;
      4'd3: w_alu_result = '0;
`endif
      4'd4: w_alu_result = op_a + ONE;
      4'd5: w_alu_result = op_a - ONE;
      4'd6: w_alu_result = op_a & op_b;
      4'd7: w_alu_result = op_a | op_b;
      4'd8: w_alu_result = op_a ^ op_b;
      4'd9: w_alu_result = ~op_a;
      default: w_alu_result = '0;
    endcase
  end

  // Result register: loads only on accepted instructions, valid pulses for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result       <= '0;
      r_zero         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= instr_valid;
      if (instr_valid) begin
        r_result <= w_alu_result;
        r_zero   <= (w_alu_result == '0);
      end
    end
  end

  assign w_addr_in_range = (mem_addr < DEPTH_W);
  assign w_mem_index     = mem_addr[AW-1:0];

  // Memory array write port; contents survive reset, but writes are blocked while it is held.
  always_ff @(posedge clk) begin
    if (reset && mem_write && w_addr_in_range) begin
      r_mem[w_mem_index] <= mem_wdata;
    end
  end

  // Registered read port; sees the pre-write word on a same-edge read/write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_rdata <= '0;
    end else if (mem_read) begin
      r_mem_rdata <= w_addr_in_range ? r_mem[w_mem_index] : '0;
    end
  end

  assign result       = r_result;
  assign zero         = r_zero;
  assign result_valid = r_result_valid;
  assign mem_rdata    = r_mem_rdata;

endmodule

// File: tb/tb_alu_decode_mem_core.sv
// tb/tb_alu_decode_mem_core.sv - self-checking bench for alu_decode_mem_core
module tb_alu_decode_mem_core;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MASK = 32'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [18:0] instruction = '0;
  logic [18:0] op_a = '0;
  logic [18:0] op_b = '0;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [18:0] imm, result, mem_rdata;
  logic        result_valid, zero;
  logic [18:0] mem_addr = '0;
  logic [18:0] mem_wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alu_decode_mem_core dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .result(result), .result_valid(result_valid), .zero(zero),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  function automatic int alu_model(input int op, input int a, input int b);
    case (op)
      0: return (a + b) & MASK;
      1: return (a - b) & MASK;
      2: return MD ? int'((longint'(a) * longint'(b)) & longint'(MASK)) : 0;
      3: return MD ? ((b == 0) ? MASK : a / b) : 0;
      4: return (a + 1) & MASK;
      5: return (a - 1) & MASK;
      6: return a & b;
      7: return a | b;
      8: return a ^ b;
      9: return (~a) & MASK;
      default: return 0;
    endcase
  endfunction

  int exp_result, exp_zero, exp_valid, exp_rdata;
  int model_mem [0:1023];

  // Model state advances on the same events the design reacts to.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_result <= 0;
      exp_zero   <= 0;
      exp_valid  <= 0;
      exp_rdata  <= 0;
    end else begin
      exp_valid <= int'(instr_valid);
      if (instr_valid) begin
        exp_result <= alu_model(int'(instruction[18:15]), int'(op_a), int'(op_b));
        exp_zero   <= (alu_model(int'(instruction[18:15]), int'(op_a), int'(op_b)) == 0) ? 1 : 0;
      end
      if (mem_read) exp_rdata <= (int'(mem_addr) < 1024) ? model_mem[int'(mem_addr)] : 0;
      if (mem_write && int'(mem_addr) < 1024) model_mem[int'(mem_addr)] <= int'(mem_wdata);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_result", 32'(result), exp_result);
      check("model_zero", 32'(zero), exp_zero);
      check("model_valid", 32'(result_valid), exp_valid);
      check("model_rdata", 32'(mem_rdata), exp_rdata);
    end
  end

  typedef struct { int op; int a; int b; int res; string name; } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int op, input int a, input int b, input int res, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input int op, input int a, input int b);
    instruction = {op[3:0], 15'b0};
    op_a = a[18:0];
    op_b = b[18:0];
    instr_valid = 1'b1;
  endtask

  initial begin
    add_vec(0, 10, 20, 30, "add");
    add_vec(1, 20, 10, 10, "sub");
    add_vec(2, 3, 4, MD ? 12 : 0, "mul");
    add_vec(3, 20, 4, MD ? 5 : 0, "div");
    add_vec(4, 5, 0, 6, "inc");
    add_vec(5, 5, 0, 4, "dec");
    add_vec(6, 5, 3, 1, "and");
    add_vec(7, 5, 3, 7, "or");
    add_vec(8, 5, 3, 6, "xor");
    add_vec(9, 5, 0, 'h7FFFA, "not");
    add_vec(3, 7, 0, MD ? 'h7FFFF : 0, "div_by_zero");
    add_vec(4, 'h7FFFF, 0, 0, "inc_wrap");
    add_vec(12, 9, 9, 0, "op12");
    add_vec(1, 10, 20, 'h7FFF6, "sub_wrap");
    add_vec(5, 0, 0, 'h7FFFF, "dec_wrap");

    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset_result", 32'(result), 0);
    check("reset_valid", 32'(result_valid), 0);
    check("reset_zero", 32'(zero), 0);
    check("reset_rdata", 32'(mem_rdata), 0);
    check_en = 1'b1;

    instruction = 19'b0001_0001_0001_0001_000;
    #1;
    check("dec_opcode", 32'(opcode), 1);
    check("dec_rd", 32'(rd), 1);
    check("dec_rs1", 32'(rs1), 1);
    check("dec_rs2", 32'(rs2), 1);
    check("dec_imm", 32'(imm), 'h088);

    // Back-to-back sweep: each literal is checked one cycle after issue.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        check({vecs[i-1].name, "_res"}, 32'(result), vecs[i-1].res);
        check({vecs[i-1].name, "_zero"}, 32'(zero), (vecs[i-1].res == 0) ? 1 : 0);
        check({vecs[i-1].name, "_valid"}, 32'(result_valid), 1);
      end
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b);
    end
    @(negedge clk);
    check({vecs[vecs.size()-1].name, "_res"}, 32'(result), vecs[vecs.size()-1].res);
    instr_valid = 1'b0;
    @(negedge clk);
    check("hold_valid", 32'(result_valid), 0);
    check("hold_result", 32'(result), 'h7FFFF);

    // Memory: write then read.
    mem_addr = 19'd0; mem_wdata = 19'd42; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    check("mem_read42", 32'(mem_rdata), 42);
    // Same-edge read and write returns old data.
    mem_wdata = 19'd99; mem_write = 1'b1; mem_read = 1'b1;
    @(negedge clk);
    check("mem_rbw_old", 32'(mem_rdata), 42);
    mem_write = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    check("mem_rbw_new", 32'(mem_rdata), 99);
    // Out-of-range write ignored, read returns 0, no aliasing onto word 0.
    mem_addr = 19'd1024; mem_wdata = 19'd5; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    @(negedge clk);
    check("mem_oor_read", 32'(mem_rdata), 0);
    mem_addr = 19'd0;
    @(negedge clk);
    mem_read = 1'b0;
    check("mem_no_alias", 32'(mem_rdata), 99);

    // Asynchronous reset mid-operation.
    drive_op(0, 10, 20);
    @(negedge clk);
    check("pre_reset_result", 32'(result), 30);
    drive_op(4, 'h7FFFF, 0);
    #2 reset = 1'b0;
    #1;
    check("async_result", 32'(result), 0);
    check("async_zero", 32'(zero), 0);
    check("async_valid", 32'(result_valid), 0);
    check("async_rdata", 32'(mem_rdata), 0);
    mem_write = 1'b1; mem_wdata = 19'd7; mem_addr = 19'd0;
    @(negedge clk);
    mem_write = 1'b0;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("no_valid_after_reset", 32'(result_valid), 0);
    check("result_after_reset", 32'(result), 0);
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    check("mem_kept_over_reset", 32'(mem_rdata), 99);
    @(negedge clk);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_mem_core.md
Name: alu_decode_mem_core

Overview:
- Single-clock execution slice of the 19-bit CPU.
- Contains three parts:
  - Combinational instruction decoder.
  - 16-opcode ALU with a registered result.
  - Synchronous word-addressed data memory with a registered read port.
- Sits between the register file and writeback. Operands arrive already read from the register file; the result and the memory read data feed writeback.

Parameters:
- WIDTH, 19, datapath, instruction and address width.
- MEM_DEPTH, 1024, number of WIDTH-bit memory words.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  start one ALU operation this cycle.
- instruction  in  19  instruction word to decode and execute.
- op_a  in  19  ALU operand a.
- op_b  in  19  ALU operand b.
- opcode  out  4  decoded opcode, equal to instruction[18:15].
- rd  out  4  decoded destination register, instruction[14:11].
- rs1  out  4  decoded source register 1, instruction[10:7].
- rs2  out  4  decoded source register 2, instruction[6:3].
- imm  out  19  instruction[10:0] zero-extended to 19 bits.
- result  out  19  registered ALU result.
- result_valid  out  1  one-cycle pulse marking a new result.
- zero  out  1  registered flag: result equals 0.
- mem_addr  in  19  memory word address.
- mem_wdata  in  19  memory write data.
- mem_write  in  1  write strobe.
- mem_read  in  1  read strobe.
- mem_rdata  out  19  registered memory read data.

Behaviour:
- Decoder is purely combinational from instruction. It does not depend on instr_valid.
- ALU operations by opcode (all arithmetic is modulo 2^19, unsigned):
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 MUL: low 19 bits of a*b.
  - 3 DIV: a/b, truncated. If b=0, result is 19'h7FFFF.
  - 4 INC: a+1.
  - 5 DEC: a-1.
  - 6 AND: a&b.
  - 7 OR: a|b.
  - 8 XOR: a^b.
  - 9 NOT: ~a.
  - 10 to 15: result 0.
- ALU timing:
  - On a rising clk edge with instr_valid=1, result and zero load from the ALU output. Latency is 1 cycle.
  - result_valid is 1 in the cycle after the accepting edge, otherwise 0.
  - result and zero hold their values while instr_valid=0.
  - Back-to-back instr_valid gives one result per cycle.
- Wrap-around examples:
  - INC of 19'h7FFFF gives 0, with zero=1.
  - DEC of 0 gives 19'h7FFFF.
  - SUB with a<b wraps.
- Memory write: on a rising edge with mem_write=1 and mem_addr<MEM_DEPTH, word mem_addr takes mem_wdata.
- Memory read:
  - On a rising edge with mem_read=1, mem_rdata loads the word at mem_addr. Latency is 1 cycle.
  - mem_rdata holds while mem_read=0.
- Out-of-range address (mem_addr >= MEM_DEPTH): writes are ignored; reads return 0.
- mem_read and mem_write to the same address on the same edge: mem_rdata returns the old contents (read-before-write). The write still happens.
- The memory path and the ALU path are independent and may operate in the same cycle.
- Reset (reset=0, asynchronous):
  - Immediately clears result, zero, result_valid and mem_rdata to 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation drops the pending result; no result_valid pulse follows.
  - Release is sampled at the next rising edge. instr_valid, mem_read and mem_write are ignored while reset=0.
- Memory contents are undefined at power-up. The bench writes before reading.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL (opcode 2) and DIV (opcode 3) behave as specified above.
- Undefined:
  - No multiplier or divider is built.
  - Opcodes 2 and 3 give result 0, with zero=1 and result_valid still pulsed.
  - All other behaviour is unchanged.

Test Plan:
- Decode instruction=19'b0001_0001_0001_0001_000 -> opcode=1, rd=1, rs1=1, rs2=1, imm=19'h088.
- ALU sweep, one op per cycle with instr_valid=1, results one cycle later:
  - ADD 10,20 -> 30.
  - SUB 20,10 -> 10.
  - MUL 3,4 -> 12.
  - DIV 20,4 -> 5.
  - INC 5 -> 6.
  - DEC 5 -> 4.
  - AND 5,3 -> 1.
  - OR 5,3 -> 7.
  - XOR 5,3 -> 6.
  - NOT 5 -> 19'h7FFFA.
  - Each result is accompanied by a result_valid pulse.
- Boundary cases:
  - DIV 7,0 -> 19'h7FFFF.
  - INC 19'h7FFFF -> 0 with zero=1.
  - opcode 12 -> 0.
  - Without ALU_MULDIV_EN: MUL 3,4 -> 0.
- Memory:
  - Write 42 to address 0, then read address 0 -> mem_rdata=42 one cycle later.
  - Simultaneous read and write of 99 to address 0 -> mem_rdata=42, then a subsequent read returns 99.
  - Write to address 1024 is ignored; a read of address 1024 returns 0.
- Reset:
  - Load result=30, then assert reset between clock edges -> result, zero, result_valid and mem_rdata go to 0 without waiting for an edge.
  - After release, reading address 0 returns the previously written value.
